// File: rtl/comp_arch_pkg.sv
// Shared widths, typedefs and constants for the datapath register file and its neighbours.
package comp_arch_pkg;

    localparam int WORD_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : comp_arch_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: register-0 forcing plus, with REG_FILE_BYPASS_EN,
// write-through forwarding of the in-flight write data.
module reg_file_read_port
    import comp_arch_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AW    = REG_AW
) (
    input  logic [AW-1:0]    readAddr,
    input  logic [WIDTH-1:0] storedData,
`ifdef REG_FILE_BYPASS_EN
    input  logic             writeEn,
    input  logic [AW-1:0]    writeAddr,
    input  logic [WIDTH-1:0] writeData,
`endif
    output logic [WIDTH-1:0] readData
);

    // NOTE: readData gets a default before any if, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        readData = storedData;
`ifdef REG_FILE_BYPASS_EN
        if (writeEn && (writeAddr == readAddr)) begin
            readData = writeData;
        end
`endif
        // Checked last so register 0 wins over a bypassed write to address 0.
        if (readAddr == AW'(ZERO_REG)) begin
            readData = '0;
        end
    end

endmodule : reg_file_read_port

// File: rtl/reg_file_2r1w.sv
// 2**AW x WIDTH register file, two async read ports, one sync write port, register 0 hardwired to zero.
// Optional write-through bypass on both read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_2r1w
    import comp_arch_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AW    = REG_AW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2
);

    localparam int NumRegs = 2 ** AW;

    logic [WIDTH-1:0] regs [NumRegs];
    logic [WIDTH-1:0] storedData1;
    logic [WIDTH-1:0] storedData2;

    // NOTE: the array is built from resettable flops, not a RAM macro, because every entry must clear asynchronously.
    // NOTE: sequential state uses <= so all flops sample pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (WE && (WA != AW'(ZERO_REG))) begin
            regs[WA] <= WD;
        end
    end

    assign storedData1 = regs[RA1];
    assign storedData2 = regs[RA2];

    reg_file_read_port #(.WIDTH(WIDTH), .AW(AW)) readPort1 (
        .readAddr  (RA1),
        .storedData(storedData1),
`ifdef REG_FILE_BYPASS_EN
        .writeEn   (WE && !RST),
        .writeAddr (WA),
        .writeData (WD),
`endif
        .readData  (RD1)
    );

    reg_file_read_port #(.WIDTH(WIDTH), .AW(AW)) readPort2 (
        .readAddr  (RA2),
        .storedData(storedData2),
`ifdef REG_FILE_BYPASS_EN
        .writeEn   (WE && !RST),
        .writeAddr (WA),
        .writeData (WD),
`endif
        .readData  (RD2)
    );

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w; expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file_2r1w;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;

    // Downstream operand-select mux model: S0=0 picks RD2, S0=1 picks the immediate.
    logic        s0;
    logic [31:0] imm;
    logic [31:0] z;
    assign z = s0 ? imm : RD2;

    int total = 0;
    int bad   = 0;

    reg_file_2r1w dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge CLK);
        WE = 1'b1;
        WA = addr;
        WD = data;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    initial begin
        logic [31:0] expBefore;
        RST = 1'b1; WE = 1'b0; WA = '0; WD = '0;
        RA1 = 5'd3; RA2 = 5'd7; s0 = 1'b0; imm = 32'd123;

        @(posedge CLK); #1;
        check("reset_rd1", RD1, 32'd0);
        check("reset_rd2", RD2, 32'd0);

        @(negedge CLK); RST = 1'b0;
        repeat (2) @(posedge CLK); #1;
        check("idle_rd1", RD1, 32'd0);
        check("idle_rd2", RD2, 32'd0);

        writeReg(5'd5, 32'd10);
        RA1 = 5'd5; #1;
        check("wr5_rd1", RD1, 32'd10);

        writeReg(5'd6, 32'd20);
        RA2 = 5'd6; #1;
        check("wr6_rd2", RD2, 32'd20);
        check("mux_z", z, 32'd20);

        // Write to register 0, also observed mid-cycle to exercise the bypass zero guard.
        @(negedge CLK);
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0; RA2 = 5'd0; #1;
        check("r0_during_rd1", RD1, 32'd0);
        @(posedge CLK); #1; WE = 1'b0; #1;
        check("r0_after_rd1", RD1, 32'd0);
        check("r0_after_rd2", RD2, 32'd0);

        // Read during write on the same address.
        writeReg(5'd9, 32'd1);
        @(negedge CLK);
        WE = 1'b1; WA = 5'd9; WD = 32'd42; RA1 = 5'd9; #1;
`ifdef REG_FILE_BYPASS_EN
        expBefore = 32'd42;
`else
        expBefore = 32'd1;
`endif
        check("rdw_before_edge", RD1, expBefore);
        @(posedge CLK); #1;
        check("rdw_after_edge", RD1, 32'd42);
        WE = 1'b0;

        RA1 = 5'd5; RA2 = 5'd5; #1;
        check("same_addr_rd1", RD1, 32'd10);
        check("same_addr_rd2", RD2, 32'd10);

        // WE=0 must neither store nor forward WD.
        writeReg(5'd4, 32'd99);
        WA = 5'd4; WD = 32'd7; RA1 = 5'd4; RA2 = 5'd4;
        repeat (3) @(posedge CLK); #1;
        check("we0_hold_rd1", RD1, 32'd99);
        check("we0_hold_rd2", RD2, 32'd99);

        // Asynchronous reset mid-cycle.
        RA2 = 5'd6;
        @(negedge CLK); #2;
        RST = 1'b1; #1;
        check("async_rst_rd1", RD1, 32'd0);
        check("async_rst_rd2", RD2, 32'd0);
        WE = 1'b1; WA = 5'd4; WD = 32'd77; #1;
        check("rst_vs_we_comb", RD1, 32'd0);
        @(posedge CLK); #1;
        check("rst_vs_we_edge", RD1, 32'd0);
        @(negedge CLK); #2;
        WE = 1'b0; RST = 1'b0; #1;
        check("rst_release_rd1", RD1, 32'd0);
        check("rst_release_rd2", RD2, 32'd0);

        writeReg(5'd4, 32'd5);
        #1;
        check("post_rst_wr4", RD1, 32'd5);
        check("post_rst_r6", RD2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_2r1w
